// File: rtl/clk_meas_pkg.sv
// Shared definitions for the clock-period measurement block.
// Contents:
//   - FSM state encodings (IDLE / MEAS / LOST, 2 bits)
//   - default parameter constants for the 1 us tick checker
//   - sat_inc8: saturating 8-bit increment used by the error counter
package clk_meas_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;  // waiting for the first edge (arming)
  localparam logic [1:0] ST_MEAS = 2'd1;  // counting clk_in cycles between edges
  localparam logic [1:0] ST_LOST = 2'd2;  // no edge for TIMEOUT cycles

  localparam int CNT_W_DEF     = 16;
  localparam int EXP_PERIOD_1US = 252;
  localparam int TOL_DEF       = 4;
  localparam int TIMEOUT_DEF   = 1024;
  localparam int LOCK_CNT_DEF  = 4;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus history flop producing a one-cycle rising-edge
// pulse for a signal asynchronous to clk_in (meas clock, vsync, href, ...).
// Ports:
//   clk_in  - sampling clock
//   reset   - asynchronous, active-low reset (clears all flops)
//   sig_in  - asynchronous input
//   rise    - one clk_in-cycle pulse, 2-3 cycles after a rising edge of sig_in
module sync_edge_det (
  input  logic clk_in,
  input  logic reset,
  input  logic sig_in,
  output logic rise
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  always_comb begin
    s1_d = sig_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  // s3 is only a history flop; the edge is taken on the synchronized s2.
  assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/clk_period_meas.sv
// Measures the period of a slow asynchronous clock/strobe in clk_in cycles,
// checks it against EXP_PERIOD +/- TOL, and reports lock, loss of clock and
// a saturating error count.
// Ports:
//   clk_in       - system clock
//   reset        - asynchronous, active-low reset
//   meas_clk     - clock under test (asynchronous)
//   period       - last measured period (clk_in cycles)
//   period_valid - one-cycle pulse when period updates
//   locked       - high after LOCK_CNT consecutive in-range periods
//   timeout      - level, high while meas_clk is considered lost
//   err_cnt      - saturating count of out-of-range periods + timeout events
//   state_dbg    - current FSM state (debug observation)
// Handshake: period_valid is a push-only strobe with no ready; the consumer
// must sample period in the cycle period_valid is high. period holds its
// value until the next strobe.
module clk_period_meas
  import clk_meas_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int EXP_PERIOD = EXP_PERIOD_1US,
  parameter int TOL        = TOL_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int LOCK_CNT   = LOCK_CNT_DEF
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             meas_clk,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout,
  output logic [7:0]       err_cnt,
  output logic [1:0]       state_dbg
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] LO_LIM  = CNT_W'(EXP_PERIOD - TOL);
  localparam logic [CNT_W-1:0] HI_LIM  = CNT_W'(EXP_PERIOD + TOL);
  localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT);
  localparam logic [GW-1:0]    LOCK_N  = GW'(LOCK_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic rise;

  sync_edge_det u_sync (
    .clk_in (clk_in),
    .reset  (reset),
    .sig_in (meas_clk),
    .rise   (rise)
  );

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GW-1:0]    good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic             in_range;
  logic [GW-1:0]    good_next;

  assign in_range = (cnt_q >= LO_LIM) && (cnt_q <= HI_LIM);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    good_cnt_d     = good_cnt_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    locked_d       = locked_q;
    timeout_d      = timeout_q;
    err_cnt_d      = err_cnt_q;
    good_next      = (good_cnt_q == LOCK_N) ? good_cnt_q : good_cnt_q + GW'(1);

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rise) begin
          state_d = ST_MEAS;
          cnt_d   = CNT_ONE;
        end
      end
      ST_MEAS: begin
        // rise wins over the timeout check when both land on one cycle.
        if (rise) begin
          period_d       = cnt_q;
          period_valid_d = 1'b1;
          // Restart at 1: the rise cycle itself is the first of the new period.
          cnt_d          = CNT_ONE;
          if (in_range) begin
            good_cnt_d = good_next;
            if (good_next == LOCK_N) locked_d = 1'b1;
          end else begin
            good_cnt_d = '0;
            locked_d   = 1'b0;
            err_cnt_d  = sat_inc8(err_cnt_q);
          end
        end else if (cnt_q == TO_LIM) begin
          state_d    = ST_LOST;
          timeout_d  = 1'b1;
          locked_d   = 1'b0;
          good_cnt_d = '0;
          err_cnt_d  = sat_inc8(err_cnt_q);
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_LOST: begin
        // First edge after loss only re-arms; no period is reported.
        if (rise) begin
          state_d   = ST_MEAS;
          cnt_d     = CNT_ONE;
          timeout_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      good_cnt_q     <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      timeout_q      <= 1'b0;
      err_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      good_cnt_q     <= good_cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      timeout_q      <= timeout_d;
      err_cnt_q      <= err_cnt_d;
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;
  assign err_cnt      = err_cnt_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_clk_period_meas.sv
// Directed bench for clk_period_meas. meas_clk is driven on clk_in falling
// edges so every rising edge is exactly p clk_in cycles after the previous
// one; each reported period is therefore exactly the driven spacing.
module tb_clk_period_meas;
  import clk_meas_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk_in   = 1'b0;
  logic        reset    = 1'b0;
  logic        meas_clk = 1'b0;
  logic [15:0] period;
  logic        period_valid;
  logic        locked;
  logic        timeout;
  logic [7:0]  err_cnt;
  logic [1:0]  state_dbg;

  always #5 clk_in = ~clk_in;

  clk_period_meas #(
    .CNT_W(16), .EXP_PERIOD(252), .TOL(4), .TIMEOUT(1024), .LOCK_CNT(4)
  ) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .meas_clk     (meas_clk),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout      (timeout),
    .err_cnt      (err_cnt),
    .state_dbg    (state_dbg)
  );

  int unsigned cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Each word: {7'b0, err_cnt, locked, period} expected at a period_valid.
  logic [31:0] exp_q[$];
  int unsigned last_pv_cyc = 0;
  int          pv_count    = 0;
  logic        to_seen     = 1'b0;

  function automatic logic [31:0] pv_word(input int p, input bit l, input int e);
    return {7'b0, 8'(e), l, 16'(p)};
  endfunction

  task automatic push_exp(input int p, input bit l, input int e, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(pv_word(p, l, e));
  endtask

  always @(negedge clk_in) begin
    if (reset) begin
      if (timeout) to_seen = 1'b1;
      if (period_valid) begin
        last_pv_cyc = cyc;
        pv_count++;
        if (exp_q.size() == 0)
          check("pv_unexpected", {7'b0, err_cnt, locked, period}, 32'd0);
        else
          check("pv", {7'b0, err_cnt, locked, period}, exp_q.pop_front());
      end
    end
  end

  task automatic expect_drained(input string tag);
    check(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  task automatic gen_period(input int p);
    meas_clk = 1'b1;
    repeat (p / 2) @(negedge clk_in);
    meas_clk = 1'b0;
    repeat (p - p / 2) @(negedge clk_in);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int pv0;
    int seq_b[9];

    repeat (3) @(negedge clk_in);
    check("rst_period",  32'(period), 32'd0);
    check("rst_pv",      32'(period_valid), 32'd0);
    check("rst_locked",  32'(locked), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_err",     32'(err_cnt), 32'd0);
    check("rst_state",   32'(state_dbg), 32'(ST_IDLE));
    reset = 1'b1;
    @(negedge clk_in);

    // A: nominal 252, 6 edges -> 5 periods, lock on the 4th
    push_exp(252, 0, 0, 3);
    push_exp(252, 1, 0, 2);
    repeat (6) gen_period(252);
    expect_drained("a_drain");
    check("a_locked", 32'(locked), 32'd1);

    // B: tolerance edges; the first edge closes the last 252 of A
    seq_b = '{248, 256, 247, 257, 252, 252, 252, 252, 252};
    exp_q.push_back(pv_word(252, 1, 0));
    exp_q.push_back(pv_word(248, 1, 0));
    exp_q.push_back(pv_word(256, 1, 0));
    exp_q.push_back(pv_word(247, 0, 1));
    exp_q.push_back(pv_word(257, 0, 2));
    push_exp(252, 0, 2, 3);
    push_exp(252, 1, 2, 1);
    foreach (seq_b[i]) gen_period(seq_b[i]);
    expect_drained("b_drain");
    check("b_locked", 32'(locked), 32'd1);
    check("b_err",    32'(err_cnt), 32'd2);

    // C: stop meas_clk -> timeout 1024 cycles after the last period_valid
    w = 0;
    while (!timeout && w < 3000) begin
      @(negedge clk_in);
      w++;
    end
    check("c_timeout",  32'(timeout), 32'd1);
    check("c_to_delay", 32'(cyc - last_pv_cyc), 32'd1024);
    check("c_locked",   32'(locked), 32'd0);
    check("c_err",      32'(err_cnt), 32'd3);
    check("c_state",    32'(state_dbg), 32'(ST_LOST));
    pv0 = pv_count;
    gen_period(252);
    check("c_rearm_no_pv", 32'(pv_count - pv0), 32'd0);
    check("c_rearm_to",    32'(timeout), 32'd0);
    push_exp(252, 0, 3, 1);
    gen_period(252);
    expect_drained("c_drain");

    // D: rise lands exactly on cnt == TIMEOUT
    to_seen = 1'b0;
    push_exp(252, 0, 3, 1);
    push_exp(1024, 0, 4, 1);
    gen_period(1024);
    gen_period(252);
    expect_drained("d_drain");
    check("d_no_timeout", 32'(to_seen), 32'd0);
    check("d_period",     32'(period), 32'd1024);

    // E: lock, then reset mid-period
    push_exp(252, 0, 4, 3);
    push_exp(252, 1, 4, 1);
    repeat (4) gen_period(252);
    expect_drained("e_drain_pre");
    check("e_locked_pre", 32'(locked), 32'd1);
    repeat (50) @(negedge clk_in);
    #2 reset = 1'b0;
    #1;
    check("e_rst_period",  32'(period), 32'd0);
    check("e_rst_pv",      32'(period_valid), 32'd0);
    check("e_rst_locked",  32'(locked), 32'd0);
    check("e_rst_timeout", 32'(timeout), 32'd0);
    check("e_rst_err",     32'(err_cnt), 32'd0);
    repeat (3) @(negedge clk_in);
    reset = 1'b1;
    pv0 = pv_count;
    gen_period(252);
    check("e_arm_no_pv", 32'(pv_count - pv0), 32'd0);
    push_exp(252, 0, 0, 3);
    push_exp(252, 1, 0, 1);
    repeat (4) gen_period(252);
    expect_drained("e_drain_post");

    // F: 300 out-of-range periods -> err_cnt saturates at 255
    push_exp(252, 1, 0, 1);
    for (int k = 1; k <= 300; k++) push_exp(100, 0, (k > 255) ? 255 : k, 1);
    repeat (301) gen_period(100);
    expect_drained("f_drain");
    check("f_err_sat", 32'(err_cnt), 32'd255);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
